// File: rtl/uart_apb_regs.sv
// APB3 register bank for the UART: RX FIFO pop, TX FIFO push, sticky error flags,
// interrupt enable and baud divisor. Zero-wait-state, all outputs registered.
module uart_apb_regs #(
  parameter logic [15:0] P_BAUD_RST = 16'd434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [15:0] baudrate,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_push,
  input  logic        tx_full,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam logic [1:0] A_RXDATA = 2'd0;
  localparam logic [1:0] A_TXDATA = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_BAUD   = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic        rx_pop_q, rx_pop_d;
  logic        tx_push_q, tx_push_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] baud_q, baud_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_udf_q, rx_udf_d;
  logic        rxie_q, rxie_d;
  logic        irq_q, irq_d;
  logic        go;
  logic        set_ovf, set_udf, clr_ovf, clr_udf;

  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata[31:16]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psel && !penable) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (psel && !penable) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The bus setup cycle is the one in which the FSM moves into SETUP; every
  // side effect is decided there and lands in registers for the access cycle.
  assign go = (state_d == SETUP);

  always_comb begin
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    rx_pop_d  = 1'b0;
    tx_push_d = 1'b0;
    tx_data_d = tx_data_q;
    baud_d    = baud_q;
    rxie_d    = rxie_q;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    clr_ovf   = 1'b0;
    clr_udf   = 1'b0;
    if (go) begin
      pready_d = 1'b1;
      prdata_d = 32'd0;
      case (paddr[3:2])
        A_RXDATA: begin
          if (pwrite) begin
            pslverr_d = 1'b1;
          end else if (!rx_empty) begin
            prdata_d = {24'd0, rx_data};
            rx_pop_d = 1'b1;
          end else begin
            set_udf = 1'b1;
          end
        end
        A_TXDATA: begin
          if (!pwrite) begin
            pslverr_d = 1'b1;
          end else if (!tx_full) begin
            tx_data_d = pwdata[7:0];
            tx_push_d = 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end
        A_STATUS: begin
          if (pwrite) begin
            clr_ovf = pwdata[2];
            clr_udf = pwdata[3];
            rxie_d  = pwdata[4];
          end else begin
            prdata_d = {27'd0, rxie_q, rx_udf_q, tx_ovf_q, tx_full, rx_empty};
          end
        end
        A_BAUD: begin
          if (pwrite) baud_d = pwdata[15:0];
          else        prdata_d = {16'd0, baud_q};
        end
        default: ;
      endcase
    end
    // A fresh error event outranks a simultaneous W1C.
    tx_ovf_d = (tx_ovf_q & ~clr_ovf) | set_ovf;
    rx_udf_d = (rx_udf_q & ~clr_udf) | set_udf;
    irq_d    = rxie_q & ~rx_empty;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rx_pop_q  <= 1'b0;
      tx_push_q <= 1'b0;
      tx_data_q <= 8'd0;
      baud_q    <= P_BAUD_RST;
      tx_ovf_q  <= 1'b0;
      rx_udf_q  <= 1'b0;
      rxie_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      rx_pop_q  <= rx_pop_d;
      tx_push_q <= tx_push_d;
      tx_data_q <= tx_data_d;
      baud_q    <= baud_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_udf_q  <= rx_udf_d;
      rxie_q    <= rxie_d;
      irq_q     <= irq_d;
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign rx_pop   = rx_pop_q;
  assign tx_push  = tx_push_q;
  assign tx_data  = tx_data_q;
  assign baudrate = baud_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_apb_regs.sv
// Bench for uart_apb_regs: directed steps then random APB traffic, checked
// against a register/queue model of the UART register map.
module tb_uart_apb_regs;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = 4'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [15:0] baudrate;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_empty = 1'b1;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_push;
  logic        tx_full = 1'b0;
  logic        irq;

  uart_apb_regs #(.P_BAUD_RST(16'd434)) dut (
    .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .baudrate(baudrate), .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
    .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  logic [15:0] m_baud;
  bit          m_ovf, m_udf, m_rxie;
  logic [7:0]  m_last_tx;
  logic [7:0]  rxq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_baud = 16'd434; m_ovf = 0; m_udf = 0; m_rxie = 0; m_last_tx = 8'd0;
  endtask

  task automatic drive_rx();
    rx_empty = (rxq.size() == 0);
    rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  // Called just after a posedge; returns just after the posedge ending ACCESS.
  task automatic xfer(input bit wr, input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit exp_err, exp_pop, exp_push, rd_chk;
    exp_rd = 32'd0; exp_err = 0; exp_pop = 0; exp_push = 0;
    case (a)
      2'd0: if (wr) exp_err = 1;
            else if (rxq.size() != 0) begin exp_rd = {24'd0, rxq[0]}; exp_pop = 1; end
            else m_udf = 1;
      2'd1: if (!wr) exp_err = 1;
            else if (tx_full) m_ovf = 1;
            else begin exp_push = 1; m_last_tx = wd[7:0]; end
      2'd2: if (wr) begin
              if (wd[2]) m_ovf = 0;
              if (wd[3]) m_udf = 0;
              m_rxie = wd[4];
            end else
              exp_rd = {27'd0, m_rxie, m_udf, m_ovf, tx_full, rxq.size() == 0};
      default: if (wr) m_baud = wd[15:0]; else exp_rd = {16'd0, m_baud};
    endcase
    // STATUS reads reflect flags before this access, so sample model first
    if (a == 2'd2 && !wr) ; // value already captured above
    rd_chk = !wr || exp_err;
    psel = 1; penable = 0; pwrite = wr; paddr = {a, 2'b00}; pwdata = wd;
    @(negedge clk);
    chk("pready_setup", {31'd0, pready}, 32'd0);
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    chk("pready", {31'd0, pready}, 32'd1);
    chk("pslverr", {31'd0, pslverr}, {31'd0, exp_err});
    if (rd_chk) chk("prdata", prdata, exp_rd);
    chk("rx_pop", {31'd0, rx_pop}, {31'd0, exp_pop});
    chk("tx_push", {31'd0, tx_push}, {31'd0, exp_push});
    chk("tx_data", {24'd0, tx_data}, {24'd0, m_last_tx});
    chk("baudrate", {16'd0, baudrate}, {16'd0, m_baud});
    if (exp_pop && rx_pop) begin void'(rxq.pop_front()); drive_rx(); end
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  // Idle cycles with irq checking and optional random FIFO / full activity.
  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("irq", {31'd0, irq}, {31'd0, m_rxie && rxq.size() != 0});
      if (rnd) begin
        if (rxq.size() < 4 && $urandom_range(0, 2) == 0) begin
          rxq.push_back(8'($urandom)); drive_rx();
        end
        if ($urandom_range(0, 3) == 0) tx_full = ~tx_full;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    model_reset();
    // reset held 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_baud", {16'd0, baudrate}, 32'd434);
    chk("rst_outs", {prdata[0], pready, pslverr, rx_pop, tx_push, irq} | {26'd0, prdata != 0, 5'd0},
        32'd0);
    chk("rst_txd", {24'd0, tx_data}, 32'd0);
    @(posedge clk); #1 reset_n = 1;
    xfer(0, 2'd3, 0);                         // BAUD reads 0x1B2
    // BAUD
    xfer(1, 2'd3, 32'h0000_1234);
    xfer(0, 2'd3, 0);
    xfer(1, 2'd3, 32'hFFFF_0010);
    xfer(0, 2'd3, 0);
    // RX read and back-to-back reads
    rxq.push_back(8'hA5); drive_rx();
    xfer(0, 2'd0, 0);
    rxq.push_back(8'h11); rxq.push_back(8'h22); drive_rx();
    xfer(0, 2'd0, 0);
    xfer(0, 2'd0, 0);
    // underrun, then W1C of RX_UDF
    xfer(0, 2'd0, 0);
    xfer(0, 2'd2, 0);
    chk("status_udf", prdata, 32'h9);
    xfer(1, 2'd2, 32'h8);
    xfer(0, 2'd2, 0);
    chk("status_clr", prdata, 32'h1);
    // TX push, overflow, W1C then new overflow
    xfer(1, 2'd1, 32'h3C);
    tx_full = 1;
    xfer(1, 2'd1, 32'h55);
    xfer(0, 2'd2, 0);
    xfer(1, 2'd2, 32'h4);
    xfer(1, 2'd1, 32'h66);
    xfer(0, 2'd2, 0);
    tx_full = 0;
    // slave errors
    xfer(1, 2'd0, 32'hFF);
    xfer(0, 2'd1, 0);
    // protocol violation from IDLE: psel & penable ignored
    rxq.push_back(8'h77); drive_rx();
    psel = 1; penable = 1; pwrite = 0; paddr = 4'h0;
    @(posedge clk); #1 psel = 0; penable = 0;
    @(negedge clk);
    chk("viol_pready", {31'd0, pready}, 32'd0);
    chk("viol_pop", {31'd0, rx_pop}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 2'd0, 0);
    // irq: RXIE set, rx_empty falls
    xfer(1, 2'd2, 32'h10);
    idle(2, 0);
    rxq.push_back(8'h5A); drive_rx();
    @(posedge clk); #1;
    chk("irq_rise", {31'd0, irq}, 32'd1);
    xfer(0, 2'd0, 0);
    idle(1, 0);
    // random traffic
    for (int k = 0; k < 250; k++) begin
      logic [1:0] a;
      bit wr;
      a  = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 2), 1);
      xfer(wr, a, $urandom);
    end
    idle(1, 0);
    // reset during the setup cycle of a TXDATA write
    tx_full = 0;
    reset_n = 0; psel = 1; penable = 0; pwrite = 1; paddr = 4'h4; pwdata = 32'hC3;
    @(posedge clk); #1 reset_n = 1; psel = 0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_push", {31'd0, tx_push}, 32'd0);
    chk("rst_mid_pready", {31'd0, pready}, 32'd0);
    chk("rst_mid_txd", {24'd0, tx_data}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 2'd3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
